// File: rtl/brk_match_ctrl.sv
// Breakpoint match controller: NSLOT address slots scanned one per clock through a shared comparator.
// Define BRK_HIT_COUNT_EN to build the saturating hit counter (HIT_CNT tied to 0 otherwise).
module brk_match_ctrl #(
    parameter int unsigned NSLOT = 4,
    parameter int unsigned SW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_we,
    input  logic [SW-1:0] cfg_sel,
    input  logic [15:0]   cfg_addr,
    input  logic          cfg_en,
    input  logic [15:0]   addr,
    input  logic          addr_vld,
    output logic          addr_rdy,
    output logic          halt_req,
    input  logic          halt_ack,
    output logic [SW-1:0] hit_slot,
    input  logic          cnt_clr,
    output logic [7:0]    hit_cnt
);

    localparam logic [SW-1:0] LAST = SW'(NSLOT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        HIT  = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [15:0]       cap_q;
    logic [SW-1:0]     idx_q;
    logic              cmp_vld_q;
    logic              cmp_hit_q;
    logic [SW-1:0]     cmp_idx_q;
    logic [15:0]       slot_addr_q [NSLOT];
    logic [NSLOT-1:0]  slot_en_q;
    logic              cmp_hit_c;
    logic              enter_hit_c;

    // Slot registers; writes to nonexistent slots are dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NSLOT; i++) begin
                slot_addr_q[i] <= '0;
            end
            slot_en_q <= '0;
        end else if (cfg_we && (32'(cfg_sel) < NSLOT)) begin
            slot_addr_q[cfg_sel] <= cfg_addr;
            slot_en_q[cfg_sel]   <= cfg_en;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Compare result is registered; the decision acts on it one cycle later
    always_comb begin
        state_d     = state_q;
        cmp_hit_c   = slot_en_q[idx_q] && (slot_addr_q[idx_q] == cap_q);
        enter_hit_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (addr_vld) begin
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (cmp_vld_q && cmp_hit_q) begin
                    state_d     = HIT;
                    enter_hit_c = 1'b1;
                end else if (cmp_vld_q && (cmp_idx_q == LAST)) begin
                    state_d = IDLE;
                end
            end
            HIT: begin
                if (halt_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_q     <= '0;
            idx_q     <= '0;
            cmp_vld_q <= 1'b0;
            cmp_hit_q <= 1'b0;
            cmp_idx_q <= '0;
            hit_slot  <= '0;
            addr_rdy  <= 1'b1;
            halt_req  <= 1'b0;
        end else begin
            addr_rdy  <= (state_d == IDLE);
            halt_req  <= (state_d == HIT);
            cmp_vld_q <= (state_q == SCAN) && (state_d == SCAN);
            cmp_hit_q <= cmp_hit_c;
            cmp_idx_q <= idx_q;
            if ((state_q == IDLE) && addr_vld) begin
                cap_q <= addr;
                idx_q <= '0;
            end else if ((state_q == SCAN) && (idx_q != LAST)) begin
                idx_q <= idx_q + SW'(1);
            end
            if (enter_hit_c) begin
                hit_slot <= cmp_idx_q;
            end
        end
    end

`ifdef BRK_HIT_COUNT_EN
    localparam int unsigned CW = 8;
    logic [CW-1:0] cnt_q;

    // Saturating hit counter; clear wins over a same-cycle increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (cnt_clr) begin
            cnt_q <= '0;
        end else if (enter_hit_c && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign hit_cnt = cnt_q;
`else
    logic cnt_clr_unused;
    assign cnt_clr_unused = cnt_clr;
    assign hit_cnt        = '0;
`endif

endmodule
